// File: rtl/vigna_clint_pkg.sv
// Shared register map, reset constants and bus helpers for the vigna CLINT.
package vigna_clint_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned STRB_W     = XLEN / 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MTIME_W    = 64;
  localparam int unsigned PRESCALE_W = 16;

  // Word indices decoded from bus_addr[4:2]
  localparam logic [IDX_W-1:0] REG_MSIP        = 3'd0;
  localparam logic [IDX_W-1:0] REG_MTIMECMP_LO = 3'd1;
  localparam logic [IDX_W-1:0] REG_MTIMECMP_HI = 3'd2;
  localparam logic [IDX_W-1:0] REG_MTIME_LO    = 3'd3;
  localparam logic [IDX_W-1:0] REG_MTIME_HI    = 3'd4;
  localparam logic [IDX_W-1:0] REG_PRESCALE    = 3'd5;
  localparam logic [IDX_W-1:0] REG_EXT_PEND    = 3'd6;
  localparam logic [IDX_W-1:0] REG_EXT_EN      = 3'd7;

  localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [MTIME_W-1:0] MTIME_RST    = 64'h0;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  // Replace the bytes of old selected by wstrb with the matching bytes of wdata.
  function automatic logic [XLEN-1:0] apply_wstrb(input logic [XLEN-1:0]   old,
                                                   input logic [XLEN-1:0]   wdata,
                                                   input logic [STRB_W-1:0] wstrb);
    logic [XLEN-1:0] res;
    res = old;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vigna_clint_sync.sv
// Two-flop synchronizer for an asynchronous line plus a rising-edge detector.
module vigna_clint_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/vigna_clint.sv
// Core-local interruptor: prescaled 64-bit mtime/mtimecmp, MSIP and a latched
// external interrupt, behind a simple valid/ready register bus.
module vigna_clint
  import vigna_clint_pkg::*;
#(
  parameter int unsigned PRESCALE_RST = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic [XLEN-1:0]   bus_wdata,
  input  logic [STRB_W-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_rdata,
  input  logic              ext_irq_in,
  output logic              timer_irq,
  output logic              soft_irq,
  output logic              ext_irq
);

  bus_state_e             state;
  bus_req_t               req_c;
  logic                   access_c;
  logic                   wr_c;
  logic                   rd_c;
  logic                   tick_c;
  logic                   ext_rise_c;
  logic [XLEN-1:0]        rdata_c;

  logic                   msip;
  logic                   ext_pend;
  logic                   ext_en;
  logic [PRESCALE_W-1:0]  prescale;
  logic [PRESCALE_W-1:0]  presc_cnt;
  logic [MTIME_W-1:0]     mtime;
  logic [MTIME_W-1:0]     mtimecmp;

  logic wr_msip_c;
  logic wr_cmp_lo_c;
  logic wr_cmp_hi_c;
  logic wr_mtime_lo_c;
  logic wr_mtime_hi_c;
  logic wr_prescale_c;
  logic wr_ext_pend_c;
  logic wr_ext_en_c;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[XLEN-1:5], bus_addr[1:0]};

  assign req_c    = '{idx: bus_addr[4:2], wdata: bus_wdata, wstrb: bus_wstrb};
  assign access_c = (state == BUS_IDLE) && bus_valid;
  assign wr_c     = access_c && (req_c.wstrb != STRB_W'(0));
  assign rd_c     = access_c && (req_c.wstrb == STRB_W'(0));

  assign wr_msip_c     = wr_c && (req_c.idx == REG_MSIP);
  assign wr_cmp_lo_c   = wr_c && (req_c.idx == REG_MTIMECMP_LO);
  assign wr_cmp_hi_c   = wr_c && (req_c.idx == REG_MTIMECMP_HI);
  assign wr_mtime_lo_c = wr_c && (req_c.idx == REG_MTIME_LO);
  assign wr_mtime_hi_c = wr_c && (req_c.idx == REG_MTIME_HI);
  assign wr_prescale_c = wr_c && (req_c.idx == REG_PRESCALE);
  assign wr_ext_pend_c = wr_c && (req_c.idx == REG_EXT_PEND);
  assign wr_ext_en_c   = wr_c && (req_c.idx == REG_EXT_EN);

  assign tick_c = (presc_cnt == prescale);

  vigna_clint_sync u_ext_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (ext_irq_in),
    .rise_c   (ext_rise_c)
  );

  // Read mux; unimplemented bits return zero
  always_comb begin
    rdata_c = '0;
    case (req_c.idx)
      REG_MSIP:        rdata_c = {31'd0, msip};
      REG_MTIMECMP_LO: rdata_c = mtimecmp[31:0];
      REG_MTIMECMP_HI: rdata_c = mtimecmp[63:32];
      REG_MTIME_LO:    rdata_c = mtime[31:0];
      REG_MTIME_HI:    rdata_c = mtime[63:32];
      REG_PRESCALE:    rdata_c = {16'd0, prescale};
      REG_EXT_PEND:    rdata_c = {31'd0, ext_pend};
      REG_EXT_EN:      rdata_c = {31'd0, ext_en};
      default:         rdata_c = '0;
    endcase
  end

  // Bus handshake: one access per valid, ready held until valid drops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BUS_IDLE;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (bus_valid) begin
            state     <= BUS_RESP;
            bus_ready <= 1'b1;
            if (rd_c) bus_rdata <= rdata_c;
          end
        end
        BUS_RESP: begin
          if (!bus_valid) begin
            state     <= BUS_IDLE;
            bus_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      msip   <= 1'b0;
      ext_en <= 1'b0;
    end else begin
      if (wr_msip_c && req_c.wstrb[0])   msip   <= req_c.wdata[0];
      if (wr_ext_en_c && req_c.wstrb[0]) ext_en <= req_c.wdata[0];
    end
  end

  // A synchronized rising edge beats a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_pend <= 1'b0;
    end else if (ext_rise_c) begin
      ext_pend <= 1'b1;
    end else if (wr_ext_pend_c && req_c.wstrb[0] && req_c.wdata[0]) begin
      ext_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale <= PRESCALE_W'(PRESCALE_RST);
    end else if (wr_prescale_c) begin
      if (req_c.wstrb[0]) prescale[7:0]  <= req_c.wdata[7:0];
      if (req_c.wstrb[1]) prescale[15:8] <= req_c.wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt <= '0;
    end else if (wr_prescale_c || tick_c) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_W'(1);
    end
  end

  // Software writes to either mtime word suppress that cycle's increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtime <= MTIME_RST;
    end else if (wr_mtime_lo_c || wr_mtime_hi_c) begin
      if (wr_mtime_lo_c) mtime[31:0]  <= apply_wstrb(mtime[31:0], req_c.wdata, req_c.wstrb);
      if (wr_mtime_hi_c) mtime[63:32] <= apply_wstrb(mtime[63:32], req_c.wdata, req_c.wstrb);
    end else if (tick_c) begin
      mtime <= mtime + MTIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtimecmp <= MTIMECMP_RST;
    end else begin
      if (wr_cmp_lo_c) mtimecmp[31:0]  <= apply_wstrb(mtimecmp[31:0], req_c.wdata, req_c.wstrb);
      if (wr_cmp_hi_c) mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], req_c.wdata, req_c.wstrb);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
      ext_irq   <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      soft_irq  <= msip;
      ext_irq   <= ext_pend & ext_en;
    end
  end

endmodule

// File: doc/vigna_clint.md
VIGNA_CLINT -- requirements
Module: vigna_clint

Interface
REQ-001 Parameter PRESCALE_RST, default 0: reset value of the PRESCALE register; mtime advances every PRESCALE+1 clocks.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 bus_valid  input  1  register access request, held until bus_ready seen.
REQ-005 bus_ready  output  1  access complete; held high until bus_valid drops.
REQ-006 bus_addr  input  32  byte address; only bits [4:2] decoded.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_wstrb  input  4  byte enables; 0 = read, nonzero = write.
REQ-009 bus_rdata  output  32  read data, valid while bus_ready=1.
REQ-010 ext_irq_in  input  1  asynchronous external interrupt line.
REQ-011 timer_irq  output  1  machine timer interrupt to core.
REQ-012 soft_irq  output  1  machine software interrupt to core.
REQ-013 ext_irq  output  1  machine external interrupt to core.

Function
REQ-014 Register map (addr[4:2]): 0 MSIP[0], 1 MTIMECMP_LO, 2 MTIMECMP_HI, 3 MTIME_LO, 4 MTIME_HI, 5 PRESCALE[15:0], 6 EXT_PEND[0] (write-1-to-clear), 7 EXT_EN[0].
REQ-015 Bus FSM states IDLE and RESP; IDLE->RESP when bus_valid=1, performing the access that same edge; RESP->IDLE when bus_valid=0.
REQ-016 Latency: bus_ready asserts exactly one cycle after bus_valid first sampled high in IDLE; no second access occurs while in RESP.
REQ-017 Writes honour bus_wstrb per byte; unimplemented bits read 0 and ignore writes.
REQ-018 Reads capture bus_rdata on the IDLE->RESP edge; bus_rdata holds until next access.
REQ-019 Prescale counter increments each cycle; when it equals PRESCALE it wraps to 0 and the 64-bit mtime increments by 1 with carry into the high word; mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 Writing PRESCALE clears the prescale counter.
REQ-021 A bus write to MTIME_LO/HI takes priority over an increment in the same cycle; written bytes replace, other word unchanged, no increment that cycle.
REQ-022 timer_irq is registered: 1 in the cycle after unsigned 64-bit mtime >= mtimecmp, 0 otherwise; level, cleared only by raising mtimecmp or lowering mtime.
REQ-023 soft_irq equals MSIP[0] (registered, direct from the register).
REQ-024 ext_irq_in passes a 2-flop synchronizer; a synchronized rising edge sets EXT_PEND.
REQ-025 Rising edge and W1C to EXT_PEND in the same cycle: set wins.
REQ-026 ext_irq = EXT_PEND & EXT_EN, registered.

Reset
REQ-027 On resetn=0 immediately: FSM IDLE, bus_ready=0, bus_rdata=0, MSIP=0, mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, PRESCALE=PRESCALE_RST, prescale counter=0, EXT_PEND=0, EXT_EN=0, synchronizer flops=0, timer_irq=soft_irq=ext_irq=0.
REQ-028 Reset asserted mid-access aborts it; after release a still-high bus_valid starts a fresh access.

Structure
REQ-029 Register offsets (word indices 0-7) and reset constants for mtimecmp live in shared package vigna_clint_pkg.
REQ-030 Synchronizer plus rising-edge detector is sub-module vigna_clint_sync; all else in vigna_clint.

Verification
REQ-031 Reset, read MTIMECMP_HI -> 0xFFFFFFFF, bus_ready exactly 1 cycle after bus_valid, timer_irq=0.
REQ-032 PRESCALE=3, mtimecmp=5, mtime=0 -> mtime increments every 4 clocks; timer_irq rises 1 cycle after mtime reaches 5.
REQ-033 Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0, PRESCALE=0 -> next increment gives MTIME_HI=1, MTIME_LO=0.
REQ-034 Write MSIP=1 with wstrb=4'b0001 -> soft_irq=1; write wdata=0 with wstrb=4'b0010 -> soft_irq stays 1.
REQ-035 EXT_EN=1, pulse ext_irq_in -> ext_irq=1 within 4 cycles; W1C EXT_PEND coinciding with new rising edge -> EXT_PEND stays 1.
REQ-036 Drop resetn while bus_ready=1 -> bus_ready=0 and all registers at reset values immediately.
